// File: rtl/mult_seq_core.sv
// Iterative radix-2 shift-add multiplier: one partial-product step per clock,
// with signed operands handled by magnitude conversion and a final negate.
module mult_seq_core #(
  parameter  int DATA_WIDTH = 32,
  localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    signed_mode,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic                    result_valid,
  output logic [1:0]              state_dbg
);

  // Handshake: start is a one-cycle strobe honoured only while busy is low
  // (IDLE); busy rises on the next edge and stays high until the edge that
  // raises done. done is a one-cycle pulse coincident with the result update.
  // clear aborts at any edge without a done pulse and leaves result untouched.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH:0]     acc_q;
  logic [DATA_WIDTH-1:0]   mcand_q;
  logic [DATA_WIDTH-1:0]   mplier_q;
  logic                    neg_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    valid_q;
  logic [2*DATA_WIDTH-1:0] result_q;

  logic                    a_neg_d;
  logic                    b_neg_d;
  logic [DATA_WIDTH-1:0]   mag_a_d;
  logic [DATA_WIDTH-1:0]   mag_b_d;
  logic [DATA_WIDTH:0]     sum_d;
  logic [2*DATA_WIDTH-1:0] product_d;
  logic [2*DATA_WIDTH-1:0] result_d;

  // The most-negative operand negates to itself, which read unsigned is the
  // correct magnitude 2^(DATA_WIDTH-1).
  always_comb begin
    a_neg_d   = signed_mode & op_a[DATA_WIDTH-1];
    b_neg_d   = signed_mode & op_b[DATA_WIDTH-1];
    mag_a_d   = a_neg_d ? -op_a : op_a;
    mag_b_d   = b_neg_d ? -op_b : op_b;
    sum_d     = acc_q + {1'b0, (mplier_q[0] ? mcand_q : {DATA_WIDTH{1'b0}})};
    product_d = {acc_q[DATA_WIDTH-1:0], mplier_q};
    result_d  = neg_q ? -product_d : product_d;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= mag_a_d;
            mplier_q <= mag_b_d;
            neg_q    <= a_neg_d ^ b_neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            valid_q  <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          // Multiplier bits retire from the bottom while product bits enter from the top.
          {acc_q, mplier_q} <= {1'b0, sum_d, mplier_q[DATA_WIDTH-1:1]};
          cnt_q             <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_mult_seq_core.sv
// Directed bench for mult_seq_core: a table of products with fixed latency
// checks, then hand sequences for ignored start, back-to-back, clear and reset.
module tb_mult_seq_core;

  localparam int DW = 32;
  localparam int LAT = DW + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          clear;
  logic          signed_mode;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          busy;
  logic          done;
  logic [2*DW-1:0] result;
  logic          result_valid;
  logic [1:0]    state_dbg;

  int n_applied = 0;
  int n_miscmp  = 0;

  typedef struct {
    logic            sm;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [2*DW-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  mult_seq_core #(.DATA_WIDTH(DW)) dut (
    .ACLK         (clk),
    .ARESETN      (rst_n),
    .start        (start),
    .clear        (clear),
    .signed_mode  (signed_mode),
    .op_a         (op_a),
    .op_b         (op_b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one start strobe; returns just after the sampling edge E0.
  task automatic start_cmd(input logic sm, input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    signed_mode = sm;
    op_a        = a;
    op_b        = b;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    op_a        = DW'($urandom);
    op_b        = DW'($urandom);
    signed_mode = 1'($urandom_range(0, 1));
  endtask

  // Counts edges until done is seen; a bound that expires reports 0.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 3 * LAT; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic watch_no_done(input int cycles, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    int   lat;
    logic seen;

    vecs[0] = '{1'b0, 32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{1'b1, 32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000};
    vecs[5] = '{1'b0, 32'h8000_0000,  32'd1,          64'h0000_0000_8000_0000};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001};
    vecs[7] = '{1'b1, 32'd7,          32'hFFFF_FFFD,  64'hFFFF_FFFF_FFFF_FFEB};
    vecs[8] = '{1'b0, 32'd0,          32'h1234_5678,  64'h0000_0000_0000_0000};
    vecs[9] = '{1'b0, 32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};

    rst_n       = 1'b0;
    start       = 1'b0;
    clear       = 1'b0;
    signed_mode = 1'b0;
    op_a        = '0;
    op_b        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   64'(busy), 64'd0);
    check("reset_done",   64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_valid",  64'(result_valid), 64'd0);
    check("reset_state",  64'(state_dbg), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven products
    foreach (vecs[i]) begin
      start_cmd(vecs[i].sm, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
      check($sformatf("v%0d_state", i), 64'(state_dbg), 64'd1);
      check($sformatf("v%0d_valid_clr", i), 64'(result_valid), 64'd0);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("v%0d_result", i), result, vecs[i].exp);
      check($sformatf("v%0d_valid", i), 64'(result_valid), 64'd1);
      check($sformatf("v%0d_busy_end", i), 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
    end

    // start while busy is ignored
    start_cmd(1'b0, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    op_a  = 32'd2;
    op_b  = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("busy_start_latency", 64'(lat), 64'(LAT - 10));
    check("busy_start_result", result, 64'd63);

    // start in the done cycle is accepted
    start_cmd(1'b0, 32'd2, 32'd2);
    check("b2b_valid_clr", 64'(result_valid), 64'd0);
    check("b2b_result_held", result, 64'd63);
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(lat);
    check("b2b_latency", 64'(lat), 64'(LAT));
    check("b2b_result", result, 64'd4);

    // clear mid-operation
    start_cmd(1'b0, 32'd7, 32'd9);
    wait_done(lat);
    check("pre_clear_result", result, 64'd63);
    start_cmd(1'b0, 32'd6, 32'd6);
    repeat (11) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_busy",   64'(busy), 64'd0);
    check("clear_done",   64'(done), 64'd0);
    check("clear_valid",  64'(result_valid), 64'd0);
    check("clear_result", result, 64'd63);
    check("clear_state",  64'(state_dbg), 64'd0);
    watch_no_done(2 * LAT, seen);
    check("clear_no_done", 64'(seen), 64'd0);
    check("clear_result_late", result, 64'd63);

    // reset mid-operation
    start_cmd(1'b0, 32'd7, 32'd9);
    wait_done(lat);
    check("pre_rst_result", result, 64'd63);
    start_cmd(1'b0, 32'd6, 32'd6);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_done",   64'(done), 64'd0);
    check("rst_valid",  64'(result_valid), 64'd0);
    check("rst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done(2 * LAT, seen);
    check("rst_no_done", 64'(seen), 64'd0);
    check("rst_result_late", result, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
    $finish;
  end

endmodule
